// File: rtl/adrv9001_tx_framer.sv
// rtl/adrv9001_tx_framer.sv - ADRV9001 SSI LVDS transmit framer (16-bit I/Q, 2 clk per sample)
module adrv9001_tx_framer #(
    parameter logic [15:0] STROBE_WORD = 16'h8000,
    parameter bit          DBG_EN      = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        enable_mode,
    input  logic [15:0] enable_delay,
    input  logic [15:0] disable_delay,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [7:0]  i_data,
    output logic [7:0]  q_data,
    output logic [7:0]  strobe,
    output logic        serdes_rst,
    output logic        adrv9001_enable,
    output logic        underflow,
    output logic [15:0] underflow_cnt,
    output logic [31:0] dbg
);

    typedef enum logic [1:0] {IDLE, EN_WAIT, ACTIVE, DIS_WAIT} state_t;

    state_t      state;
    logic        ph;
    logic [15:0] cnt;
    logic [7:0]  lo_i;
    logic [7:0]  lo_q;
    logic [15:0] en_dly;
    logic [15:0] dis_dly;

    // SPI-controlled enable has no pin latency to hide, so both delays collapse to zero
    assign en_dly        = enable_mode ? enable_delay  : 16'd0;
    assign dis_dly       = enable_mode ? disable_delay : 16'd0;
    assign s_axis_tready = (state == ACTIVE) && !ph;
    assign dbg           = DBG_EN ? {13'd0, state, ph, cnt} : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            ph              <= 1'b0;
            cnt             <= 16'd0;
            lo_i            <= 8'd0;
            lo_q            <= 8'd0;
            i_data          <= 8'd0;
            q_data          <= 8'd0;
            strobe          <= 8'd0;
            serdes_rst      <= 1'b1;
            adrv9001_enable <= 1'b0;
            underflow       <= 1'b0;
            underflow_cnt   <= 16'd0;
        end else begin
            adrv9001_enable <= enable & enable_mode;
            underflow       <= 1'b0;
            ph              <= (state == IDLE) ? 1'b0 : ~ph;
            case (state)
                IDLE: begin
                    i_data     <= 8'd0;
                    q_data     <= 8'd0;
                    strobe     <= 8'd0;
                    serdes_rst <= 1'b1;
                    if (enable) begin
                        state         <= EN_WAIT;
                        cnt           <= en_dly;
                        underflow_cnt <= 16'd0;
                        serdes_rst    <= 1'b0;
                    end
                end
                EN_WAIT: begin
                    i_data     <= 8'd0;
                    q_data     <= 8'd0;
                    strobe     <= 8'd0;
                    serdes_rst <= 1'b0;
                    if (!enable) begin
                        state      <= IDLE;
                        ph         <= 1'b0;
                        serdes_rst <= 1'b1;
                    end else if (ph) begin
                        if (cnt == 16'd0) state <= ACTIVE;
                        else              cnt   <= cnt - 16'd1;
                    end
                end
                ACTIVE, DIS_WAIT: begin
                    if (!ph) begin
                        // slot boundary: latch the whole sample, emit the high bytes now
                        if (state == ACTIVE && s_axis_tvalid) begin
                            i_data <= s_axis_tdata[31:24];
                            q_data <= s_axis_tdata[15:8];
                            lo_i   <= s_axis_tdata[23:16];
                            lo_q   <= s_axis_tdata[7:0];
                        end else begin
                            i_data <= 8'd0;
                            q_data <= 8'd0;
                            lo_i   <= 8'd0;
                            lo_q   <= 8'd0;
                        end
                        if (state == ACTIVE && !s_axis_tvalid) begin
                            underflow <= 1'b1;
                            if (underflow_cnt != 16'hFFFF)
                                underflow_cnt <= underflow_cnt + 16'd1;
                        end
                        strobe <= STROBE_WORD[15:8];
                    end else begin
                        i_data <= lo_i;
                        q_data <= lo_q;
                        strobe <= STROBE_WORD[7:0];
                        if (state == ACTIVE) begin
                            if (!enable) begin
                                state <= DIS_WAIT;
                                cnt   <= dis_dly;
                            end
                        end else if (cnt == 16'd0) begin
                            state      <= IDLE;
                            serdes_rst <= 1'b1;
                        end else begin
                            cnt <= cnt - 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adrv9001_tx_framer.sv
// tb/tb_adrv9001_tx_framer.sv - randomized self-checking bench for adrv9001_tx_framer
module tb_adrv9001_tx_framer;

    localparam logic [15:0] STROBE = 16'h8000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        enable_mode;
    logic [15:0] enable_delay;
    logic [15:0] disable_delay;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [7:0]  i_data;
    logic [7:0]  q_data;
    logic [7:0]  strobe;
    logic        serdes_rst;
    logic        adrv9001_enable;
    logic        underflow;
    logic [15:0] underflow_cnt;
    logic [31:0] dbg;

    int checks = 0;
    int errors = 0;

    bit          sv [0:63];
    logic [31:0] sd [0:63];

    adrv9001_tx_framer #(.STROBE_WORD(STROBE), .DBG_EN(1'b0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .enable_mode(enable_mode),
        .enable_delay(enable_delay), .disable_delay(disable_delay),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .i_data(i_data), .q_data(q_data), .strobe(strobe), .serdes_rst(serdes_rst),
        .adrv9001_enable(adrv9001_enable), .underflow(underflow), .underflow_cnt(underflow_cnt),
        .dbg(dbg)
    );

    always #5 clk = ~clk;

    // Sample slots on the wire: k data slots starting at cycle a, then d+1 zero slots.
    function automatic bit slot_word(input int s, input int a, input int k, input int d,
                                     output logic [31:0] w, output bit uf);
        w = 32'd0;
        uf = 1'b0;
        slot_word = 1'b0;
        if (s >= a && ((s - a) % 2) == 0) begin
            int j;
            j = (s - a) / 2;
            if (j < k) begin
                slot_word = 1'b1;
                w  = sv[j] ? sd[j] : 32'd0;
                uf = !sv[j];
            end else if (j <= k + d) begin
                slot_word = 1'b1;
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scenario(input bit mode, input logic [15:0] edly, input logic [15:0] ddly,
                                input int k, input bit directed);
        int e, d, a, drop, idle_c, eucnt;
        logic [31:0] w;
        logic [15:0] sw;
        logic [7:0]  ei, eq, es;
        bit uf, hit, euf, etr, esr, ead;
        sw = STROBE;
        e = mode ? int'(edly) : 0;
        d = mode ? int'(ddly) : 0;
        a = 3 + 2 * e;
        drop = a + 2 * k - 2 + int'($urandom_range(0, 1));
        idle_c = a + 2 * k + 2 * d + 2;
        if (!directed) begin
            for (int j = 0; j < k; j++) begin
                sv[j] = ($urandom_range(0, 3) != 0);
                sd[j] = $urandom;
            end
        end
        enable_mode   = mode;
        enable_delay  = edly;
        disable_delay = ddly;
        for (int c = 0; c <= idle_c + 2; c++) begin
            enable = (c < drop);
            etr = (c >= a) && (((c - a) % 2) == 0) && ((c - a) / 2 < k);
            if (etr) begin
                s_axis_tvalid = sv[(c - a) / 2];
                s_axis_tdata  = sd[(c - a) / 2];
            end else begin
                s_axis_tvalid = 1'($urandom_range(0, 1));
                s_axis_tdata  = $urandom;
            end
            ei = 8'd0; eq = 8'd0; es = 8'd0; euf = 1'b0;
            hit = slot_word(c - 1, a, k, d, w, uf);
            if (hit) begin
                ei = w[31:24]; eq = w[15:8]; es = sw[15:8]; euf = uf;
            end else begin
                hit = slot_word(c - 2, a, k, d, w, uf);
                if (hit) begin
                    ei = w[23:16]; eq = w[7:0]; es = sw[7:0];
                end
            end
            esr = (c <= 0) || (c >= idle_c);
            ead = mode && (c >= 1) && (c - 1 < drop);
            eucnt = 0;
            for (int j = 0; j < k; j++)
                if (!sv[j] && a + 2 * j + 1 <= c) eucnt++;

            checks += 8;
            if (i_data !== ei) begin errors++; $display("FAIL i_data c=%0d got %h want %h", c, i_data, ei); end
            if (q_data !== eq) begin errors++; $display("FAIL q_data c=%0d got %h want %h", c, q_data, eq); end
            if (strobe !== es) begin errors++; $display("FAIL strobe c=%0d got %h want %h", c, strobe, es); end
            if (s_axis_tready !== etr) begin errors++; $display("FAIL tready c=%0d got %b want %b", c, s_axis_tready, etr); end
            if (serdes_rst !== esr) begin errors++; $display("FAIL serdes_rst c=%0d got %b want %b", c, serdes_rst, esr); end
            if (adrv9001_enable !== ead) begin errors++; $display("FAIL adrv_enable c=%0d got %b want %b", c, adrv9001_enable, ead); end
            if (underflow !== euf) begin errors++; $display("FAIL underflow c=%0d got %b want %b", c, underflow, euf); end
            if (dbg !== 32'd0) begin errors++; $display("FAIL dbg c=%0d got %h want 0", c, dbg); end
            if (c > 0) begin
                checks++;
                if (underflow_cnt !== 16'(eucnt)) begin
                    errors++;
                    $display("FAIL underflow_cnt c=%0d got %0d want %0d", c, underflow_cnt, eucnt);
                end
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; enable_mode = 1'b0; enable_delay = 16'd0; disable_delay = 16'd0;
        s_axis_tvalid = 1'b0; s_axis_tdata = 32'd0;
        step();
        step();
        checks++;
        if ({i_data, q_data, strobe, s_axis_tready, serdes_rst, adrv9001_enable, underflow, underflow_cnt, dbg}
            !== {24'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_values got i=%h q=%h s=%h tr=%b sr=%b en=%b uf=%b uc=%0d want 0 except serdes_rst=1",
                     i_data, q_data, strobe, s_axis_tready, serdes_rst, adrv9001_enable, underflow, underflow_cnt);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_pin_mode_examples();
        sv[0] = 1'b1; sd[0] = 32'h1234_ABCD;
        sv[1] = 1'b0; sd[1] = 32'hFFFF_FFFF;
        sv[2] = 1'b0; sd[2] = 32'h5555_AAAA;
        sv[3] = 1'b1; sd[3] = $urandom;
        run_scenario(1'b1, 16'd3, 16'd2, 4, 1'b1);
    endtask

    task automatic test_spi_mode();
        run_scenario(1'b0, 16'd5, 16'd5, 3, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++)
            run_scenario(1'($urandom_range(0, 1)), 16'($urandom_range(0, 6)),
                         16'($urandom_range(0, 5)), int'($urandom_range(1, 12)), 1'b0);
    endtask

    task automatic test_en_wait_abort();
        enable_mode = 1'b1; enable_delay = 16'd4; disable_delay = 16'd0;
        s_axis_tvalid = 1'b1; s_axis_tdata = $urandom;
        enable = 1'b1;
        for (int c = 0; c < 3; c++) step();
        enable = 1'b0;
        step();
        for (int c = 0; c < 4; c++) begin
            checks += 2;
            if (serdes_rst !== 1'b1) begin errors++; $display("FAIL abort_serdes_rst c=%0d got %b want 1", c, serdes_rst); end
            if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL abort_tready c=%0d got %b want 0", c, s_axis_tready); end
            step();
        end
    endtask

    task automatic test_reset_mid_sample();
        enable_mode = 1'b1; enable_delay = 16'd0; disable_delay = 16'd0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'hCAFE_F00D;
        enable = 1'b1;
        for (int c = 0; c < 4; c++) step();
        checks++;
        if (i_data !== 8'hCA) begin errors++; $display("FAIL rst_mid_hibyte got %h want ca", i_data); end
        rst = 1'b1;
        enable = 1'b0;
        step();
        checks++;
        if ({i_data, q_data, strobe, s_axis_tready, serdes_rst, adrv9001_enable, underflow_cnt}
            !== {24'd0, 1'b0, 1'b1, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL rst_mid_outputs got i=%h q=%h s=%h tr=%b sr=%b en=%b uc=%0d want 0 with serdes_rst=1",
                     i_data, q_data, strobe, s_axis_tready, serdes_rst, adrv9001_enable, underflow_cnt);
        end
        rst = 1'b0;
        step();
        checks++;
        if ({i_data, strobe, serdes_rst} !== {16'd0, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid_settled got i=%h s=%h sr=%b want 0 0 1", i_data, strobe, serdes_rst);
        end
        run_scenario(1'b1, 16'd1, 16'd1, 3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_pin_mode_examples();
        test_spi_mode();
        test_random();
        test_en_wait_abort();
        test_reset_mid_sample();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
